// File: rtl/rf_dbg_pkg.sv
// -----------------------------------------------------------------------------
// rf_dbg_pkg
// Shared definitions for the register-file debug access block: register-file
// geometry and the controller state encoding.
// -----------------------------------------------------------------------------
package rf_dbg_pkg;

    localparam int REG_ADDR_W = 5;   // x0..x31
    localparam int XLEN       = 32;  // register width

    typedef enum logic [2:0] {
        ST_IDLE, // no command, core free to run
        ST_HALT, // command latched, waiting for the core to stop
        ST_EXEC, // single cycle that owns the register-file ports
        ST_RESP, // response offered until consumed
        ST_HOLD  // core kept halted a few cycles in case another command follows
    } dbg_state_e;

endpackage

// File: rtl/rf_debug_access.sv
// -----------------------------------------------------------------------------
// rf_debug_access
// Lets a debugger read or write the core register file. The core is first
// asked to halt (halt_req/halt_ack), then the command is executed in a single
// cycle on the register-file ports, and a response is returned. After the
// response the core is kept halted for HOLD_CYCLES idle cycles so that a
// burst of debug commands does not pay the halt handshake each time.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata    command: 1 = write, target register, write data
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_err       read data (0 for writes), 1 = write to x0 refused
//   halt_req/halt_ack       halt request to the core / core is stopped
//   rf_rd_addr/rf_rd_data   register-file read port 1 (combinational data)
//   rf_wr_en/addr/data      register-file write port
//
// HOLD_CYCLES: idle cycles halt_req stays high after a response, 1..15.
// -----------------------------------------------------------------------------
module rf_debug_access
    import rf_dbg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [REG_ADDR_W-1:0] cmd_addr,
    input  logic [XLEN-1:0]       cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err,

    output logic                  halt_req,
    input  logic                  halt_ack,

    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    input  logic [XLEN-1:0]       rf_rd_data,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data
);

    // The hold counter is 4 bits wide, which bounds HOLD_CYCLES to 15.
    localparam logic [3:0] HOLD_LOAD = HOLD_CYCLES[3:0];

    dbg_state_e            state;
    dbg_state_e            next_state;

    logic                  accept;
    logic                  wr_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [3:0]            hold_cnt;
    logic                  wr_to_x0;

    // cmd_ready is gated by rst_n so that it reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign cmd_ready = rst_n && ((state == ST_IDLE) || (state == ST_HOLD));
    assign accept    = cmd_valid && cmd_ready;
    assign wr_to_x0  = (addr_q == '0);

    // The latched address drives both ports directly; no extra muxing needed.
    assign rf_rd_addr = addr_q;
    assign rf_wr_addr = addr_q;
    assign rf_wr_data = wdata_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        next_state = state;
        halt_req   = 1'b1;
        rsp_valid  = 1'b0;
        rf_wr_en   = 1'b0;

        case (state)
            ST_IDLE: begin
                halt_req = 1'b0;
                if (accept) begin
                    next_state = ST_HALT;
                end
            end

            ST_HALT: begin
                if (halt_ack) begin
                    next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Writes to x0 are refused: x0 is hardwired to zero.
                rf_wr_en   = wr_q && !wr_to_x0;
                next_state = ST_RESP;
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // A new command takes priority over counter expiry. If the
                // core has since resumed (halt_ack low) it must halt again.
                if (accept) begin
                    next_state = halt_ack ? ST_EXEC : ST_HALT;
                end else if (hold_cnt <= 4'd1) begin
                    next_state = ST_IDLE;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command latch, response capture and hold counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            if (accept) begin
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end

            // Response fields are captured once, at the end of EXEC, and then
            // stay put for the whole RESP state.
            if (state == ST_EXEC) begin
                rsp_rdata <= wr_q ? '0 : rf_rd_data;
                rsp_err   <= wr_q && wr_to_x0;
            end

            if ((state == ST_RESP) && rsp_ready) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == ST_HOLD) begin
                hold_cnt <= accept ? 4'd0 : (hold_cnt - 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_rf_debug_access.sv
// -----------------------------------------------------------------------------
// tb_rf_debug_access
// Self-checking bench for rf_debug_access. A transaction-level model tracks
// whether a command is outstanding, whether the halt has been granted, the
// pending response and the remaining quiet cycles; a compare process checks
// the DUT against it every falling edge. Directed scenarios pin latencies and
// data with literal values, then a randomized phase exercises the rest.
// -----------------------------------------------------------------------------
module tb_rf_debug_access;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        halt_req;
    logic        halt_ack;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int checks   = 0;
    int failures = 0;
    int wr_pulses = 0;

    always #5 clk = ~clk;

    rf_debug_access #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .halt_req   (halt_req),
        .halt_ack   (halt_ack),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    // Register file attached to the DUT ports; x0 always reads as zero.
    logic [31:0] rf [32] = '{default: 32'h0};
    assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'h0 : rf[rf_rd_addr];
    always @(posedge clk) begin
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model (transaction level)
    // ---------------------------------------------------------------------
    bit          m_in_flight = 0; // command accepted, response not yet consumed
    bit          m_need_ack  = 0; // waiting for the core to report halted
    bit          m_exec      = 0; // this cycle owns the register-file ports
    bit          m_resp      = 0; // response being offered
    int          m_quiet     = 0; // quiet cycles left before the halt is released
    bit          m_wr        = 0;
    logic [4:0]  m_addr      = 5'd0;
    logic [31:0] m_wdata     = 32'h0;
    logic [31:0] m_rdata     = 32'h0;
    bit          m_err       = 0;
    logic [31:0] m_mem [32]  = '{default: 32'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_flight <= 0;
            m_need_ack  <= 0;
            m_exec      <= 0;
            m_resp      <= 0;
            m_quiet     <= 0;
            m_wr        <= 0;
            m_addr      <= 5'd0;
            m_wdata     <= 32'h0;
            m_rdata     <= 32'h0;
            m_err       <= 0;
        end else if (cmd_valid && !m_in_flight) begin
            m_in_flight <= 1;
            m_wr        <= cmd_write;
            m_addr      <= cmd_addr;
            m_wdata     <= cmd_wdata;
            m_quiet     <= 0;
            // Still halted from a previous command: skip the halt handshake.
            if (m_quiet > 0 && halt_ack) m_exec <= 1;
            else                         m_need_ack <= 1;
        end else if (m_need_ack) begin
            if (halt_ack) begin
                m_need_ack <= 0;
                m_exec     <= 1;
            end
        end else if (m_exec) begin
            m_exec  <= 0;
            m_resp  <= 1;
            m_rdata <= (m_wr || m_addr == 5'd0) ? 32'h0 : m_mem[m_addr];
            m_err   <= m_wr && (m_addr == 5'd0);
            if (m_wr && m_addr != 5'd0) m_mem[m_addr] <= m_wdata;
        end else if (m_resp) begin
            if (rsp_ready) begin
                m_resp      <= 0;
                m_in_flight <= 0;
                m_quiet     <= HOLD;
            end
        end else if (m_quiet > 0) begin
            m_quiet <= m_quiet - 1;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        bit exp_wr;
        exp_wr = m_exec && m_wr && (m_addr != 5'd0);
        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, rst_n && !m_in_flight});
        check("halt_req",  {31'b0, halt_req},  {31'b0, m_in_flight || (m_quiet > 0)});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_resp});
        check("rf_wr_en",  {31'b0, rf_wr_en},  {31'b0, exp_wr});
        check("rf_rd_addr", {27'b0, rf_rd_addr}, {27'b0, m_addr});
        if (exp_wr) begin
            check("rf_wr_addr", {27'b0, rf_wr_addr}, {27'b0, m_addr});
            check("rf_wr_data", rf_wr_data, m_wdata);
        end
        if (m_resp) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err",   {31'b0, rsp_err}, {31'b0, m_err});
        end
        if (rf_wr_en) wr_pulses++;
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command for one cycle; returns just after the accept edge.
    task automatic present(input bit w, input logic [4:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF; // garbage after accept must be ignored
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"},  {31'b0, cmd_ready}, 32'h0);
        check({tag, "_rsp_valid"},  {31'b0, rsp_valid}, 32'h0);
        check({tag, "_rsp_rdata"},  rsp_rdata, 32'h0);
        check({tag, "_rsp_err"},    {31'b0, rsp_err}, 32'h0);
        check({tag, "_halt_req"},   {31'b0, halt_req}, 32'h0);
        check({tag, "_rf_wr_en"},   {31'b0, rf_wr_en}, 32'h0);
        check({tag, "_rf_wr_addr"}, {27'b0, rf_wr_addr}, 32'h0);
        check({tag, "_rf_wr_data"}, rf_wr_data, 32'h0);
        check({tag, "_rf_rd_addr"}, {27'b0, rf_rd_addr}, 32'h0);
    endtask

    // Pulses reset in the middle of a cycle and checks the immediate effect.
    task automatic mid_cycle_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_all_zero(tag);
        #10 rst_n = 1'b1;
        #1 check({tag, "_ready_after_release"}, {31'b0, cmd_ready}, 32'h1);
        check({tag, "_halt_after_release"}, {31'b0, halt_req}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        int p;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 5'd0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        halt_ack  = 1'b1;

        #2 check_all_zero("por");
        #20 rst_n = 1'b1;
        #1 check("por_ready_after_release", {31'b0, cmd_ready}, 32'h1);
        tick();

        // Write x5 with halt_ack tied high: HALT, EXEC, then response.
        p = wr_pulses;
        present(1'b1, 5'd5, 32'hDEAD_BEEF);
        check("w5_halt_req", {31'b0, halt_req}, 32'h1);
        check("w5_no_early_wr", {31'b0, rf_wr_en}, 32'h0);
        tick();
        check("w5_wr_en", {31'b0, rf_wr_en}, 32'h1);
        check("w5_wr_addr", {27'b0, rf_wr_addr}, 32'd5);
        check("w5_wr_data", rf_wr_data, 32'hDEAD_BEEF);
        check("w5_rsp_not_yet", {31'b0, rsp_valid}, 32'h0);
        tick();
        check("w5_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("w5_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("w5_rsp_rdata", rsp_rdata, 32'h0);
        check("w5_one_pulse", wr_pulses - p, 32'd1);
        handshake();
        check("w5_rsp_dropped", {31'b0, rsp_valid}, 32'h0);
        for (int i = 0; i < HOLD - 1; i++) begin
            tick();
            check("w5_hold_halt_req", {31'b0, halt_req}, 32'h1);
        end
        tick();
        check("w5_halt_released", {31'b0, halt_req}, 32'h0);

        // Read x5 back.
        present(1'b0, 5'd5, 32'h0);
        tick(2);
        check("r5_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("r5_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("r5_err", {31'b0, rsp_err}, 32'h0);
        check("r5_model_rdata", m_rdata, 32'hDEAD_BEEF);
        handshake();

        // Write x0 two cycles into HOLD: straight to EXEC, refused.
        p = wr_pulses;
        tick();
        present(1'b1, 5'd0, 32'h1234_5678);
        check("w0_halt_kept", {31'b0, halt_req}, 32'h1);
        check("w0_no_wr", {31'b0, rf_wr_en}, 32'h0);
        tick();
        check("w0_rsp_valid_k2", {31'b0, rsp_valid}, 32'h1);
        check("w0_err", {31'b0, rsp_err}, 32'h1);
        check("w0_model_err", {31'b0, m_err}, 32'h1);
        check("w0_no_pulse", wr_pulses - p, 32'd0);
        handshake();
        tick();
        present(1'b0, 5'd0, 32'h0);
        tick();
        check("r0_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        check("r0_rdata", rsp_rdata, 32'h0);
        check("r0_err", {31'b0, rsp_err}, 32'h0);
        handshake();
        tick(HOLD);
        check("r0_halt_released", {31'b0, halt_req}, 32'h0);

        // Delayed halt_ack (7 cycles) and slow response consumer.
        p = wr_pulses;
        halt_ack = 1'b0;
        present(1'b1, 5'd7, 32'hA5A5_0001);
        for (int i = 0; i < 7; i++) begin
            check("slow_halt_req", {31'b0, halt_req}, 32'h1);
            check("slow_no_early_wr", {31'b0, rf_wr_en}, 32'h0);
            tick();
        end
        halt_ack = 1'b1;
        tick();
        check("slow_wr_en", {31'b0, rf_wr_en}, 32'h1);
        halt_ack = 1'b0; // dropping during EXEC must not abort
        tick();
        for (int i = 0; i < 3; i++) begin
            check("slow_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            check("slow_rsp_rdata", rsp_rdata, 32'h0);
            check("slow_rsp_err", {31'b0, rsp_err}, 32'h0);
            check("slow_halt_held", {31'b0, halt_req}, 32'h1);
            tick();
        end
        check("slow_one_pulse", wr_pulses - p, 32'd1);
        handshake();
        halt_ack = 1'b1;
        tick(HOLD);
        check("slow_halt_released", {31'b0, halt_req}, 32'h0);

        // Reset during HALT: no write may follow.
        p = wr_pulses;
        halt_ack = 1'b0;
        present(1'b1, 5'd9, 32'h1111_1111);
        mid_cycle_reset("rst_halt");
        halt_ack = 1'b1;
        tick(3);
        check("rst_halt_no_wr", wr_pulses - p, 32'd0);
        check("rst_halt_x9", rf[9], 32'h0);

        // Reset during RESP of a read returning non-zero data.
        present(1'b0, 5'd5, 32'h3333_3333);
        tick(2);
        check("rst_resp_valid_before", {31'b0, rsp_valid}, 32'h1);
        mid_cycle_reset("rst_resp");

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_write = $urandom_range(0, 1) == 1;
            cmd_addr  = 5'($urandom_range(0, 7));
            cmd_wdata = $urandom;
            halt_ack  = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        halt_ack  = 1'b1;
        tick(20);
        check("final_halt_released", {31'b0, halt_req}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
